// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - MSB-first priority encoder with registered result and change-detect pulse
module priority_encoder #(
    parameter int WIDTH = 4,
    parameter int YW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] I,
    output logic [YW-1:0]    Y,
    output logic             valid,
    output logic [WIDTH-1:0] grant,
    output logic [YW-1:0]    y_q,
    output logic             valid_q,
    output logic             changed
);

    logic [YW-1:0]    w_y;
    logic             w_valid;
    logic [WIDTH-1:0] w_grant;

    logic [YW-1:0]    r_y_q;
    logic             r_valid_q;
    logic             r_changed;

    // Ascending scan: a later (higher) set bit overrides any lower one.
    always_comb begin
        w_y     = '0;
        w_valid = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (I[k]) begin
                w_y     = YW'(k);
                w_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_valid) begin
            w_grant = WIDTH'(1) << w_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q     <= '0;
            r_valid_q <= 1'b0;
            r_changed <= 1'b0;
        end else if (en) begin
            r_y_q     <= w_y;
            r_valid_q <= w_valid;
            r_changed <= ({w_y, w_valid} != {r_y_q, r_valid_q});
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign Y       = w_y;
    assign valid   = w_valid;
    assign grant   = w_grant;
    assign y_q     = r_y_q;
    assign valid_q = r_valid_q;
    assign changed = r_changed;

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - scoreboard bench for priority_encoder (WIDTH = 4)
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] I;
    logic [1:0] Y;
    logic       valid;
    logic [3:0] grant;
    logic [1:0] y_q;
    logic       valid_q;
    logic       changed;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] y;
        logic       v;
        logic [3:0] g;
    } comb_exp_t;

    typedef struct {
        logic [1:0] yq;
        logic       vq;
        logic       ch;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];

    priority_encoder #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .I       (I),
        .Y       (Y),
        .valid   (valid),
        .grant   (grant),
        .y_q     (y_q),
        .valid_q (valid_q),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic pop_comb(input string tag);
        comb_exp_t e;
        if (comb_q.size() == 0) begin
            chk({tag, "_queue"}, 4'd0, 4'd1);
            return;
        end
        e = comb_q.pop_front();
        chk({tag, "_Y"}, {2'b00, Y}, {2'b00, e.y});
        chk({tag, "_valid"}, {3'b000, valid}, {3'b000, e.v});
        chk({tag, "_grant"}, grant, e.g);
    endtask

    task automatic pop_reg(input string tag);
        reg_exp_t e;
        if (reg_q.size() == 0) begin
            chk({tag, "_queue"}, 4'd0, 4'd1);
            return;
        end
        e = reg_q.pop_front();
        chk({tag, "_y_q"}, {2'b00, y_q}, {2'b00, e.yq});
        chk({tag, "_valid_q"}, {3'b000, valid_q}, {3'b000, e.vq});
        chk({tag, "_changed"}, {3'b000, changed}, {3'b000, e.ch});
    endtask

    task automatic comb_step(input string tag, input logic [3:0] i,
                             input logic [1:0] ey, input logic ev, input logic [3:0] eg);
        comb_exp_t e;
        I = i;
        e.y = ey; e.v = ev; e.g = eg;
        comb_q.push_back(e);
        #1;
        pop_comb(tag);
    endtask

    task automatic clk_step(input string tag, input logic r, input logic e_en, input logic [3:0] i,
                            input logic [1:0] eyq, input logic evq, input logic ech);
        reg_exp_t e;
        rst = r; en = e_en; I = i;
        e.yq = eyq; e.vq = evq; e.ch = ech;
        reg_q.push_back(e);
        @(posedge clk);
        #1;
        pop_reg(tag);
    endtask

    // Reference: scan down from the MSB and stop at the first set bit.
    function automatic logic [1:0] ref_y(input logic [3:0] v);
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) return 2'(k);
        end
        return 2'b00;
    endfunction

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        I   = 4'b0000;

        comb_step("sweep_1010", 4'b1010, 2'b11, 1'b1, 4'b1000); #9;
        comb_step("sweep_0101", 4'b0101, 2'b10, 1'b1, 4'b0100); #9;
        comb_step("sweep_0011", 4'b0011, 2'b01, 1'b1, 4'b0010); #9;
        comb_step("sweep_1000", 4'b1000, 2'b11, 1'b1, 4'b1000); #9;
        comb_step("sweep_1111", 4'b1111, 2'b11, 1'b1, 4'b1000); #9;
        comb_step("zero_0000",  4'b0000, 2'b00, 1'b0, 4'b0000); #9;
        comb_step("lsb_0001",   4'b0001, 2'b00, 1'b1, 4'b0001);

        @(posedge clk);
        #1;

        clk_step("rst_1", 1'b1, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
        clk_step("rst_2", 1'b1, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
        comb_step("rst_comb", 4'b1111, 2'b11, 1'b1, 4'b1000);
        clk_step("rel_load",   1'b0, 1'b1, 4'b1111, 2'b11, 1'b1, 1'b1);
        clk_step("rel_steady", 1'b0, 1'b1, 4'b1111, 2'b11, 1'b1, 1'b0);

        clk_step("hold_1", 1'b0, 1'b0, 4'b0011, 2'b11, 1'b1, 1'b0);
        clk_step("hold_2", 1'b0, 1'b0, 4'b0011, 2'b11, 1'b1, 1'b0);
        clk_step("hold_3", 1'b0, 1'b0, 4'b0011, 2'b11, 1'b1, 1'b0);
        clk_step("hold_en",    1'b0, 1'b1, 4'b0011, 2'b01, 1'b1, 1'b1);
        clk_step("hold_after", 1'b0, 1'b1, 4'b0011, 2'b01, 1'b1, 1'b0);

        clk_step("cd_rst",   1'b1, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        clk_step("cd_zero",  1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        clk_step("cd_0100",  1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1);
        clk_step("cd_0110",  1'b0, 1'b1, 4'b0110, 2'b10, 1'b1, 1'b0);
        clk_step("cd_0010",  1'b0, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b1);
        clk_step("cd_to_0",  1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b1);

        clk_step("mid_load", 1'b0, 1'b1, 4'b1001, 2'b11, 1'b1, 1'b1);
        clk_step("mid_rst",  1'b1, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
        comb_step("mid_comb", 4'b1111, 2'b11, 1'b1, 4'b1000);

        for (int v = 0; v < 16; v++) begin
            logic [3:0] iv;
            logic [1:0] ey;
            logic       ev;
            iv = 4'(v);
            ey = ref_y(iv);
            ev = (iv != 4'b0000);
            comb_step($sformatf("exh_%b", iv), iv, ey, ev, ev ? (4'b0001 << ey) : 4'b0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
